counter_event_monitor: RTL

Downstream consumer of the 8-bit up/down counter's `qd` output. Samples the count every cycle, classifies transitions (wrap-up, wrap-down, threshold hit, non-unit jump from a load), and queues one event record per cycle in a small show-ahead FIFO. Events drain over a valid/ready interface to the status/interrupt logic.

---
 rtl/counter_event_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/counter_event_monitor.sv
// rtl/counter_event_monitor.sv - counter transition classifier with show-ahead event FIFO (optional COUNTER_EVENT_MONITOR_TIMESTAMP_EN)
module counter_event_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         qd,
  input  logic [DATA_WIDTH-1:0]         thresh,
  input  logic                          mon_en,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [1:0]                    evt_code,
  output logic [DATA_WIDTH-1:0]         evt_value,
  output logic [$clog2(FIFO_DEPTH):0]   evt_level,
  output logic                          overflow
`ifdef COUNTER_EVENT_MONITOR_TIMESTAMP_EN
  ,
  output logic [15:0]                   evt_ts
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] MAX_VAL = '1;
  localparam logic [DATA_WIDTH-1:0] ONE_VAL = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]           PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] CODE_JUMP   = 2'b00;
  localparam logic [1:0] CODE_WRAPUP = 2'b01;
  localparam logic [1:0] CODE_WRAPDN = 2'b10;
  localparam logic [1:0] CODE_THRESH = 2'b11;

  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_vld;
  logic                  det;
  logic [1:0]            det_code;

  logic [1:0]            mem_code  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_value [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  pop;
  logic                  push;

`ifdef COUNTER_EVENT_MONITOR_TIMESTAMP_EN
  logic [15:0]           ts_cnt;
  logic [15:0]           mem_ts [FIFO_DEPTH];
`endif

  // Previous-sample register; validity follows the enable so a fresh enable never fires on stale data
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev     <= qd;
      prev_vld <= mon_en;
    end
  end

  // Classify the prev->qd transition, highest priority first, one event at most
  always_comb begin
    det      = 1'b0;
    det_code = CODE_JUMP;
    if (mon_en && prev_vld) begin
      if (prev == MAX_VAL && qd == '0) begin
        det      = 1'b1;
        det_code = CODE_WRAPUP;
      end else if (prev == '0 && qd == MAX_VAL) begin
        det      = 1'b1;
        det_code = CODE_WRAPDN;
      end else if (qd == thresh && prev != thresh) begin
        det      = 1'b1;
        det_code = CODE_THRESH;
      end else if (qd != prev && qd != prev + ONE_VAL && qd != prev - ONE_VAL) begin
        det      = 1'b1;
        det_code = CODE_JUMP;
      end
    end
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = (level != '0) && evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the new event
  assign push  = det && (!full || pop);

  // FIFO storage, pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_code[i]  <= '0;
        mem_value[i] <= '0;
`ifdef COUNTER_EVENT_MONITOR_TIMESTAMP_EN
        mem_ts[i]    <= '0;
`endif
      end
    end else begin
      if (push) begin
        mem_code[wr_ptr[AW-1:0]]  <= det_code;
        mem_value[wr_ptr[AW-1:0]] <= qd;
`ifdef COUNTER_EVENT_MONITOR_TIMESTAMP_EN
        mem_ts[wr_ptr[AW-1:0]]    <= ts_cnt;
`endif
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (det && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef COUNTER_EVENT_MONITOR_TIMESTAMP_EN
  // Free-running cycle counter stamped into each event
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
    end
  end

  assign evt_ts = mem_ts[rd_ptr[AW-1:0]];
`endif

  assign evt_valid = (level != '0);
  assign evt_code  = mem_code[rd_ptr[AW-1:0]];
  assign evt_value = mem_value[rd_ptr[AW-1:0]];
  assign evt_level = level;

endmodule
